// File: rtl/ahb_apb_pkg.sv
// ---------------------------------------------------------------------------
// ahb_apb_pkg
// Shared encodings for the AHB-Lite to APB3 bridge:
//   - HTRANS transfer-type encodings
//   - HRESP response encodings
//   - bridge FSM state enumeration
// No ports (package).
// ---------------------------------------------------------------------------
package ahb_apb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_ACCESS,
    ST_DONE,
    ST_ERR1,
    ST_ERR2
  } bridge_state_e;

endpackage

// File: rtl/ahb_apb_bridge.sv
// ---------------------------------------------------------------------------
// ahb_apb_bridge
// AHB-Lite slave that turns single AHB transfers into APB3 transfers on a
// single APB segment sharing HCLK. One outstanding transfer at a time.
//
// Ports:
//   HCLK, HRESETn          clock, asynchronous active-low reset
//   HSEL/HADDR/HTRANS/     AHB address phase from the matrix
//   HWRITE/HSIZE/HREADY
//   HWDATA                 AHB write data (data phase)
//   HRDATA/HREADYOUT/HRESP registered AHB slave response
//   PADDR/PSEL/PENABLE/    APB master outputs (PWDATA mirrors HWDATA)
//   PWRITE/PWDATA
//   PRDATA/PREADY/PSLVERR  APB slave response
//
// Build option: define APB_BRIDGE_TIMEOUT_EN to abort ACCESS with an ERROR
// response after TIMEOUT_CYCLES cycles of PREADY=0.
// ---------------------------------------------------------------------------
module ahb_apb_bridge
  import ahb_apb_pkg::*;
#(
  parameter int PADDR_WIDTH    = 16,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                   HCLK,
  input  logic                   HRESETn,
  input  logic                   HSEL,
  input  logic [31:0]            HADDR,
  input  logic [1:0]             HTRANS,
  input  logic                   HWRITE,
  input  logic [2:0]             HSIZE,
  input  logic [31:0]            HWDATA,
  input  logic                   HREADY,
  output logic [31:0]            HRDATA,
  output logic                   HREADYOUT,
  output logic                   HRESP,
  output logic [PADDR_WIDTH-1:0] PADDR,
  output logic                   PSEL,
  output logic                   PENABLE,
  output logic                   PWRITE,
  output logic [31:0]            PWDATA,
  input  logic [31:0]            PRDATA,
  input  logic                   PREADY,
  input  logic                   PSLVERR
);

  bridge_state_e           state_q, state_d;
  logic [PADDR_WIDTH-1:0]  paddr_q, paddr_d;
  logic                    pwrite_q, pwrite_d;
  logic [2:0]              hsize_q, hsize_d;
  logic [31:0]             hrdata_q, hrdata_d;
  logic                    hreadyout_q, hreadyout_d;
  logic                    hresp_q, hresp_d;
  logic                    psel_q, psel_d;
  logic                    penable_q, penable_d;
  logic                    accept;
  logic                    timeout_hit;

  assign accept = HSEL & HTRANS[1] & HREADY;

`ifdef APB_BRIDGE_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] tmo_cnt_q, tmo_cnt_d;

  // The count after this cycle's increment reaching TIMEOUT_CYCLES means
  // this is the TIMEOUT_CYCLES-th ACCESS cycle without PREADY.
  assign timeout_hit = (tmo_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  // Outside ACCESS the counter sits at zero, so it is clear on entry.
  always_comb begin
    tmo_cnt_d = '0;
    if (state_q == ST_ACCESS && !PREADY) begin
      tmo_cnt_d = tmo_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      tmo_cnt_q <= '0;
    end else begin
      tmo_cnt_q <= tmo_cnt_d;
    end
  end
`else
  localparam int UNUSED_TIMEOUT_CYCLES = TIMEOUT_CYCLES;
  assign timeout_hit = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    paddr_d  = paddr_q;
    pwrite_d = pwrite_q;
    hsize_d  = hsize_q;
    hrdata_d = hrdata_q;

    case (state_q)
      ST_IDLE, ST_DONE, ST_ERR2: begin
        if (accept) begin
          state_d  = ST_SETUP;
          paddr_d  = HADDR[PADDR_WIDTH-1:0];
          pwrite_d = HWRITE;
          hsize_d  = HSIZE;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SETUP: state_d = ST_ACCESS;
      ST_ACCESS: begin
        // PREADY wins over a timeout landing on the same cycle.
        if (PREADY) begin
          if (PSLVERR) begin
            state_d = ST_ERR1;
          end else begin
            state_d = ST_DONE;
            if (!pwrite_q) hrdata_d = PRDATA;
          end
        end else if (timeout_hit) begin
          state_d = ST_ERR1;
        end
      end
      ST_ERR1: state_d = ST_ERR2;
      default: state_d = ST_IDLE;
    endcase

    // Outputs are registered, so decode them from the next state.
    hreadyout_d = (state_d == ST_IDLE) || (state_d == ST_DONE) || (state_d == ST_ERR2);
    hresp_d     = ((state_d == ST_ERR1) || (state_d == ST_ERR2)) ? HRESP_ERROR : HRESP_OKAY;
    psel_d      = (state_d == ST_SETUP) || (state_d == ST_ACCESS);
    penable_d   = (state_d == ST_ACCESS);
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q     <= ST_IDLE;
      paddr_q     <= '0;
      pwrite_q    <= 1'b0;
      hsize_q     <= 3'd0;
      hrdata_q    <= 32'd0;
      hreadyout_q <= 1'b1;
      hresp_q     <= HRESP_OKAY;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      paddr_q     <= paddr_d;
      pwrite_q    <= pwrite_d;
      hsize_q     <= hsize_d;
      hrdata_q    <= hrdata_d;
      hreadyout_q <= hreadyout_d;
      hresp_q     <= hresp_d;
      psel_q      <= psel_d;
      penable_q   <= penable_d;
    end
  end

  // HWDATA stays stable for the whole data phase because HREADYOUT is low.
  assign PWDATA    = HWDATA;
  assign PADDR     = paddr_q;
  assign PWRITE    = pwrite_q;
  assign PSEL      = psel_q;
  assign PENABLE   = penable_q;
  assign HRDATA    = hrdata_q;
  assign HREADYOUT = hreadyout_q;
  assign HRESP     = hresp_q;

  // HSIZE is captured but APB3 has no size signal; upper address bits and
  // HTRANS[0] do not affect the bridge.
  logic unused_inputs;
  assign unused_inputs = ^{HADDR[31:PADDR_WIDTH], HTRANS[0], hsize_q};

endmodule

// File: doc/ahb_apb_bridge.md
Name: ahb_apb_bridge

Overview:
- AHB-Lite slave that converts single AHB transfers into APB3 transfers.
- Occupies one slave port of the matrix, e.g. s6, driven by the matrix's HSEL/HADDR/HTRANS/HWRITE/HSIZE/HWDATA/HREADY.
- Returns HRDATA, HREADYOUT and HRESP on that slave port.
- Serves low-speed peripherals behind a single APB segment; one outstanding transfer at a time.

Parameters:
- PADDR_WIDTH, 16, width of PADDR; taken from the low HADDR bits.
- TIMEOUT_CYCLES, 255, ACCESS-state wait limit, used only with APB_BRIDGE_TIMEOUT_EN; range 1..65535.

Ports:
- HCLK  in  1  clock; the APB segment runs on the same clock.
- HRESETn  in  1  asynchronous active-low reset.
- HSEL  in  1  slave select from the matrix decoder.
- HADDR  in  32  address-phase address.
- HTRANS  in  2  transfer type; bit1 set means NONSEQ/SEQ.
- HWRITE  in  1  write when high.
- HSIZE  in  3  size; only captured.
- HWDATA  in  32  write data, valid in the data phase.
- HREADY  in  1  bus-wide ready (sN_HREADY).
- HRDATA  out  32  read data, registered.
- HREADYOUT  out  1  slave ready, registered.
- HRESP  out  1  0=OKAY, 1=ERROR, registered.
- PADDR  out  PADDR_WIDTH  APB address.
- PSEL  out  1  APB select.
- PENABLE  out  1  APB enable.
- PWRITE  out  1  APB direction.
- PWDATA  out  32  APB write data.
- PRDATA  in  32  APB read data.
- PREADY  in  1  APB ready.
- PSLVERR  in  1  APB error.

Behaviour:
- Reset (asynchronous, HRESETn=0):
  - State=IDLE, HREADYOUT=1, HRESP=0, HRDATA=0.
  - PSEL=0, PENABLE=0, PWRITE=0, PADDR=0.
  - Any in-flight APB transfer is dropped with no completion.
- Transfer accept: valid = HSEL & HTRANS[1] & HREADY, sampled on a rising edge in states IDLE, DONE or ERR2. On accept, latch HADDR[PADDR_WIDTH-1:0] and HWRITE; next state is SETUP.
- IDLE/BUSY handling: HTRANS IDLE or BUSY with HSEL=1 gets a zero-wait OKAY and causes no APB activity.
- State SETUP (1 cycle): PSEL=1, PENABLE=0, HREADYOUT=0; goes to ACCESS.
- State ACCESS:
  - PSEL=1, PENABLE=1, HREADYOUT=0.
  - PREADY=0: stay in ACCESS.
  - PREADY=1 & PSLVERR=0: latch PRDATA into HRDATA on reads (HRDATA unchanged on writes); go to DONE.
  - PREADY=1 & PSLVERR=1: go to ERR1.
- State DONE: PSEL=0, PENABLE=0, HREADYOUT=1, HRESP=0. Accept or go to IDLE.
- State ERR1: HREADYOUT=0, HRESP=1, PSEL=0.
- State ERR2: HREADYOUT=1, HRESP=1. Accept or go to IDLE. The transfer accepted here is executed normally; the master is responsible for cancelling it via HTRANS=IDLE.
- PWDATA is driven combinationally as HWDATA. HWDATA is stable for the whole data phase because HREADY is low.
- PADDR and PWRITE hold their values through SETUP and ACCESS and hold after completion until the next accept; no glitching.
- Latency with a zero-wait APB slave is 2 AHB wait states (SETUP, ACCESS), then DONE. Each PREADY=0 cycle adds one wait state.
- Back-to-back transfers: an accept in DONE goes straight to SETUP, with no idle APB cycle.
- An ERROR response always lasts two cycles (ERR1 then ERR2), as AHB-Lite requires.

Optional Feature:
- Macro: APB_BRIDGE_TIMEOUT_EN.
- With the macro:
  - A counter of width clog2(TIMEOUT_CYCLES+1) clears on entry to ACCESS and increments each ACCESS cycle while PREADY=0.
  - When the counter equals TIMEOUT_CYCLES with PREADY still 0: drop PSEL/PENABLE, go to ERR1. HRDATA is unchanged.
  - PREADY=1 on the same cycle takes priority over the timeout.
- Without the macro: there is no counter and ACCESS can wait indefinitely.

Decomposition:
- Package ahb_apb_pkg holds:
  - HTRANS encodings (IDLE, BUSY, NONSEQ, SEQ).
  - HRESP_OKAY/HRESP_ERROR.
  - the bridge state enum (IDLE, SETUP, ACCESS, DONE, ERR1, ERR2).
- No sub-module. The timeout counter lives inline under the macro.

Test Plan:
- Read, PREADY tied 1, PRDATA=32'hA5A5_0001, HADDR=32'h4000_0010: PSEL high 2 cycles, PADDR=16'h0010, HREADYOUT low 2 cycles, HRDATA=32'hA5A5_0001, HRESP=0.
- Write HWDATA=32'hDEAD_BEEF, PREADY held 0 for 3 ACCESS cycles: PWDATA=32'hDEAD_BEEF and PWRITE=1 throughout, HREADYOUT low 5 cycles.
- Read with PSLVERR=1 on completion: HRESP=1 for two cycles, HREADYOUT 0 then 1; the next NONSEQ accepted in ERR2 completes OKAY.
- Two back-to-back NONSEQ writes to 16'h0004 and 16'h0008: the second SETUP immediately follows DONE; PSEL never low between the two APB transfers except in DONE.
- HRESETn asserted mid-ACCESS: PSEL, PENABLE and HRDATA are 0 and HREADYOUT is 1 immediately (asynchronous); after release an IDLE HTRANS gives zero-wait OKAY.
- With APB_BRIDGE_TIMEOUT_EN, TIMEOUT_CYCLES=4, PREADY stuck 0: ERR1 entered after 4 ACCESS cycles, HRESP=1 for two cycles.
